// File: rtl/recording_player.sv
// recording_player: steps through {note,duration} entries of a recording RAM and
// drives the tone generator note code, with looping, stop and restart.
module recording_player #(
  parameter int TICK_DIV = 500000,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] rec_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [6:0]        ascii_out,
  output logic              playing,
  output logic              done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, len, len_n;
  logic [6:0] note_n;
  logic [8:0] dur, dur_n;
  logic [PW-1:0] presc, presc_n;
  logic done_n, fin, last, tick;
  assign last = ADDR_W'(idx + 1'b1) == len;
  assign tick = presc == PMAX;
  assign rd_en = state == FETCH;
  assign playing = state != IDLE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    len_n = len;
    note_n = ascii_out;
    dur_n = dur;
    presc_n = '0;
    done_n = 1'b0;
    fin = 1'b0;
    if (stop) begin
      state_n = IDLE;
      note_n = '0;
    end else if (start) begin
      len_n = rec_len;
      idx_n = '0;
      state_n = rec_len == '0 ? IDLE : FETCH;
      done_n = rec_len == '0;
      note_n = rec_len == '0 ? 7'd0 : ascii_out;
    end else begin
      case (state)
        FETCH: state_n = WAIT;
        WAIT: begin
          fin = rd_data[8:0] == '0;
          note_n = fin ? ascii_out : rd_data[15:9];
          dur_n = fin ? dur : rd_data[8:0];
          state_n = fin ? WAIT : PLAY;
        end
        PLAY: begin
          presc_n = tick ? '0 : presc + 1'b1;
          if (tick) begin
            dur_n = dur - 1'b1;
            if (dur == 9'd1) begin
              fin = last;
              idx_n = idx + 1'b1;
              state_n = FETCH;
            end
          end
        end
        default: ;
      endcase
    end
    // completion: loop back to the first entry or finish with a done pulse
    if (fin) begin
      idx_n = '0;
      state_n = loop_en ? FETCH : IDLE;
      note_n = loop_en ? note_n : 7'd0;
      done_n = !loop_en;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      ascii_out <= '0;
      dur <= '0;
      presc <= '0;
      done <= 1'b0;
      rd_addr <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      len <= len_n;
      ascii_out <= note_n;
      dur <= dur_n;
      presc <= presc_n;
      done <= done_n;
      if (state_n == FETCH) rd_addr <= idx_n;
    end
  end
endmodule

// File: tb/tb_recording_player.sv
// tb_recording_player: directed playback scenarios with a RAM model and hand-computed timing.
module tb_recording_player;
  localparam int TD = 4;
  localparam int AW = 8;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [AW-1:0] rec_len = '0;
  logic rd_en, playing, done;
  logic [AW-1:0] rd_addr;
  logic [15:0] rd_data;
  logic [6:0] ascii_out;
  logic [15:0] mem [256];
  logic [6:0] na, nb;
  logic [AW-1:0] addrs [$];
  int vec = 0, bad = 0;
  int n_a, n_b, n_done, t_done, n_rd, t_a, max_addr;

  recording_player #(.TICK_DIV(TD), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
    .rec_len(rec_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ascii_out(ascii_out), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'hffff;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    n_a = 0; n_b = 0; n_done = 0; t_done = -1; n_rd = 0; t_a = -1; max_addr = 0;
    addrs.delete();
    for (int t = 1; t <= n; t++) begin
      step();
      start = 1'b0;
      stop = 1'b0;
      if (rd_en) begin
        n_rd++;
        addrs.push_back(rd_addr);
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (ascii_out == na) begin
        n_a++;
        if (t_a < 0) t_a = t;
      end
      if (ascii_out == nb) n_b++;
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
    end
  endtask

  function automatic logic [AW-1:0] addr_at(input int i);
    return addrs.size() > i ? addrs[i] : 8'hee;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    step();
    step();
    check("rst_playing", playing, 0);
    check("rst_ascii", ascii_out, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;

    mem[0] = {7'h41, 9'd2}; mem[1] = {7'h42, 9'd1};
    na = 7'h41; nb = 7'h42;
    rec_len = 2; start = 1'b1; run(20);
    check("basic_first_41", t_a, 3);
    check("basic_41_cycles", n_a, 10);
    check("basic_42_cycles", n_b, 4);
    check("basic_done_cnt", n_done, 1);
    check("basic_done_cycle", t_done, 17);
    check("basic_reads", n_rd, 2);
    check("basic_addr0", addr_at(0), 0);
    check("basic_addr1", addr_at(1), 1);
    check("basic_end_ascii", ascii_out, 0);
    check("basic_end_playing", playing, 0);

    rec_len = 0; start = 1'b1; run(5);
    check("empty_done_cnt", n_done, 1);
    check("empty_done_cycle", t_done, 1);
    check("empty_reads", n_rd, 0);
    check("empty_playing", playing, 0);

    mem[0] = {7'h43, 9'd1}; mem[1] = {7'h55, 9'd0};
    na = 7'h43; nb = 7'h55;
    rec_len = 5; loop_en = 1'b1; start = 1'b1; run(40);
    check("loop_43_cycles", n_a, 38);
    check("loop_marker_note", n_b, 0);
    check("loop_no_done", n_done, 0);
    check("loop_reads", n_rd, 10);
    check("loop_addr0", addr_at(0), 0);
    check("loop_addr1", addr_at(1), 1);
    check("loop_addr2", addr_at(2), 0);
    check("loop_addr3", addr_at(3), 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("loop_stop_ascii", ascii_out, 0);
    check("loop_stop_playing", playing, 0);
    check("loop_stop_done", done, 0);
    loop_en = 1'b0;

    mem[0] = {7'h41, 9'd2}; mem[1] = {7'h42, 9'd1};
    na = 7'h41; nb = 7'h42;
    rec_len = 2; start = 1'b1; run(5);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("stopstart_playing", playing, 0);
    check("stopstart_ascii", ascii_out, 0);
    check("stopstart_done", done, 0);
    run(10);
    check("stopstart_reads", n_rd, 0);
    check("stopstart_done_cnt", n_done, 0);

    start = 1'b1; run(14);
    check("rstmid_pre_addr", rd_addr, 1);
    check("rstmid_pre_ascii", ascii_out, 7'h42);
    resetn = 1'b0; start = 1'b1; step(); start = 1'b0;
    check("rstmid_ascii", ascii_out, 0);
    check("rstmid_rd_en", rd_en, 0);
    check("rstmid_rd_addr", rd_addr, 0);
    check("rstmid_playing", playing, 0);
    check("rstmid_done", done, 0);
    resetn = 1'b1; step();
    check("rstmid_start_dropped", playing, 0);
    start = 1'b1; run(3);
    check("rstmid_replay_addr", addr_at(0), 0);
    check("rstmid_replay_note", t_a, 3);
    run(20);

    start = 1'b1; run(14);
    start = 1'b1; run(20);
    check("restart_addr", addr_at(0), 0);
    check("restart_first_41", t_a, 3);
    check("restart_41_cycles", n_a, 10);
    check("restart_done_cycle", t_done, 17);

    mem[0] = {7'h50, 9'd511}; na = 7'h50;
    rec_len = 1; start = 1'b1; run(2060);
    check("d511_cycles", n_a, 2044);
    check("d511_done_cycle", t_done, 2047);
    check("d511_reads", n_rd, 1);

    for (int i = 0; i < 255; i++) mem[i] = {7'h20, 9'd1};
    mem[255] = {7'h7f, 9'd1};
    na = 7'h20; nb = 7'h7f;
    rec_len = 255; start = 1'b1; run(1540);
    check("full_reads", n_rd, 255);
    check("full_max_addr", max_addr, 254);
    check("full_no_extra", n_b, 0);
    check("full_note_cycles", n_a, 1528);
    check("full_done_cycle", t_done, 1531);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
